// File: rtl/regfile_32x64.sv
// regfile_32x64: 32 x WIDTH register file fed by a one-hot write enable.
// Two registered read ports with write-first bypass, optional hardwired-zero
// register 31, and a registered error flag for multi-hot write enables.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset_n    - asynchronous active-low reset
//   wrEn       - one-hot write enable, bit i selects register i
//   writeData  - data written to the selected register
//   readReg1/2 - read addresses, sampled each rising edge
//   readData1/2- registered read data (1-cycle latency)
//   wrErr      - high the cycle after a wrEn with two or more bits set
module regfile_32x64 #(
    parameter int unsigned WIDTH    = 64,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      wrEn,
    input  logic [WIDTH-1:0] writeData,
    input  logic [4:0]       readReg1,
    input  logic [4:0]       readReg2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             wrErr
);

    localparam int unsigned NREG = 32;
    localparam logic [4:0]  ZERO_IDX = 5'd31;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] rd1_d, rd2_d;
    logic             multi_hot_c;
    logic [31:0]      wr_mask_c;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hot_c = (wrEn & (wrEn - 32'd1)) != 32'd0;

    // Effective write mask: empty on multi-hot, register 31 masked when hardwired.
    always_comb begin
        wr_mask_c = multi_hot_c ? 32'd0 : wrEn;
        if (ZERO_REG) begin
            wr_mask_c[31] = 1'b0;
        end
    end

    // Read muxes with write-first bypass from the effective write mask.
    always_comb begin
        rd1_d = wr_mask_c[readReg1] ? writeData : regs_q[readReg1];
        rd2_d = wr_mask_c[readReg2] ? writeData : regs_q[readReg2];
        if (ZERO_REG && (readReg1 == ZERO_IDX)) begin
            rd1_d = '0;
        end
        if (ZERO_REG && (readReg2 == ZERO_IDX)) begin
            rd2_d = '0;
        end
    end

    // Register array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_mask_c[i]) begin
                    regs_q[i] <= writeData;
                end
            end
        end
    end

    // Registered read data and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readData1 <= '0;
            readData2 <= '0;
            wrErr     <= 1'b0;
        end else begin
            readData1 <= rd1_d;
            readData2 <= rd2_d;
            wrErr     <= multi_hot_c;
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
module tb_regfile_32x64;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  wrEn;
    logic [W-1:0] writeData;
    logic [4:0]   readReg1, readReg2;
    logic [W-1:0] readData1, readData2;
    logic         wrErr;

    regfile_32x64 #(.WIDTH(W), .ZERO_REG(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wrEn      (wrEn),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .wrErr     (wrErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check64(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic cyc(input string name, input logic [31:0] we, input logic [W-1:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [W-1:0] e1, input logic [W-1:0] e2, input logic ee);
        exp_t e;
        @(negedge clk);
        wrEn = we; writeData = wd; readReg1 = r1; readReg2 = r2;
        e.name = name; e.d1 = e1; e.d2 = e2; e.err = ee;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: outputs settle just after each edge; compare against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check64({e.name, ".rd1"}, readData1, e.d1);
            check64({e.name, ".rd2"}, readData2, e.d2);
            check1 ({e.name, ".err"}, wrErr, e.err);
        end
    end

    localparam logic [W-1:0] DB   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] Z    = 64'h0;

    initial begin
        int budget;
        reset_n = 1'b0; wrEn = '0; writeData = '0; readReg1 = '0; readReg2 = '0;
        #12;
        check64("reset.rd1", readData1, Z);
        check1 ("reset.err", wrErr, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cyc("read_all", 32'h0, Z, 5'(i), 5'(31 - i), Z, Z, 1'b0);
        end

        cyc("wr5_byp",   32'h0000_0020, DB, 5'd5, 5'd4, DB, Z, 1'b0);
        cyc("rd5_6",     32'h0,         Z,  5'd5, 5'd6, DB, Z, 1'b0);
        cyc("rd4_5",     32'h0,         Z,  5'd4, 5'd5, Z, DB, 1'b0);
        cyc("byp9",      32'h1 << 9,    64'hA5A5, 5'd9, 5'd5, 64'hA5A5, DB, 1'b0);
        cyc("rd9",       32'h0,         Z,  5'd9, 5'd9, 64'hA5A5, 64'hA5A5, 1'b0);
        cyc("zero31",    32'h8000_0000, ONES, 5'd30, 5'd31, Z, Z, 1'b0);
        cyc("zero31_rd", 32'h0,         Z,  5'd31, 5'd31, Z, Z, 1'b0);
        cyc("multi3",    32'h0000_0003, 64'h1234, 5'd0, 5'd1, Z, Z, 1'b1);
        cyc("multi3_after", 32'h0,      Z,  5'd0, 5'd1, Z, Z, 1'b0);
        cyc("multi_a",   32'h8000_0001, ONES, 5'd0, 5'd9, Z, 64'hA5A5, 1'b1);
        cyc("multi_b",   32'hFFFF_FFFF, ONES, 5'd9, 5'd5, 64'hA5A5, DB, 1'b1);
        cyc("multi_clr", 32'h0,         Z,  5'd0, 5'd5, Z, DB, 1'b0);
        cyc("same12",    32'h1 << 12,   64'h0C0C_0C0C_0C0C_0C0C, 5'd12, 5'd12,
            64'h0C0C_0C0C_0C0C_0C0C, 64'h0C0C_0C0C_0C0C_0C0C, 1'b0);
        cyc("wr0_rd12",  32'h1,         64'h0000_0000_0000_0042, 5'd12, 5'd0,
            64'h0C0C_0C0C_0C0C_0C0C, 64'h42, 1'b0);
        cyc("wr7",       32'h1 << 7,    64'h77, 5'd7, 5'd5, 64'h77, DB, 1'b0);
        cyc("rd7",       32'h0,         Z,  5'd7, 5'd0, 64'h77, 64'h42, 1'b0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check64("async.rd1", readData1, Z);
        check64("async.rd2", readData2, Z);
        check1 ("async.err", wrErr, 1'b0);
        #1 reset_n = 1'b1;

        cyc("post_rd7",  32'h0,         Z,  5'd7, 5'd5, Z, Z, 1'b0);
        cyc("post_rd0",  32'h0,         Z,  5'd0, 5'd9, Z, Z, 1'b0);
        cyc("post_wr7",  32'h1 << 7,    64'h88, 5'd7, 5'd7, 64'h88, 64'h88, 1'b0);
        cyc("post_rd7b", 32'h0,         Z,  5'd7, 5'd0, 64'h88, Z, 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
